// File: rtl/gb_dma_pkg.sv
// Shared constants and types for the OAM DMA engine.
package gb_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR     = 16'hFF46;
  localparam logic [15:0] OAM_BASE         = 16'hFE00;
  localparam int          DMA_LENGTH       = 160;
  // Source memory returns read data this many cycles after the read strobe.
  // The WAIT0/WAIT1 states cover exactly this latency.
  localparam int          DMA_READ_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_WAIT1 = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  // Echo RAM (E0-FF) aliases the work RAM 8 KiB below it.
  function automatic logic [7:0] echo_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/dma_reg.sv
// CPU-visible DMA source register: decode, write latch and readback.
module dma_reg
  import gb_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR = DMA_REG_ADDR
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  input  logic        load,
  input  logic        store,
  output logic [7:0]  outdata,
  output logic [7:0]  src_hi,
  output logic        wr_hit
);

  logic sel;

  assign sel    = (address == REG_ADDR);
  assign wr_hit = store && sel;
  // Readback comes from the flop, so a same-cycle store shows the old value.
  assign outdata = (load && sel) ? src_hi : 8'h00;

  // Latch the source high byte on a register write.
  always_ff @(posedge clockgb) begin
    if (reset)       src_hi <= 8'h00;
    else if (wr_hit) src_hi <= indata;
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from {src,00..} to DEST_BASE,
// one byte every 4 cycles (read, two latency waits, write).
module oam_dma
  import gb_dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR  = DMA_REG_ADDR,
  parameter logic [15:0] DEST_BASE = OAM_BASE,
  parameter int          LENGTH    = DMA_LENGTH
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_outdata,
  input  logic [7:0]  dma_indata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  logic [7:0] src_hi;
  logic [7:0] src_eff;
  logic       wr_hit;
  dma_state_e state;
  logic [7:0] index;
  logic [7:0] data_q;

  dma_reg #(.REG_ADDR(REG_ADDR)) u_reg (
    .clockgb (clockgb),
    .reset   (reset),
    .address (address),
    .indata  (indata),
    .load    (load),
    .store   (store),
    .outdata (outdata),
    .src_hi  (src_hi),
    .wr_hit  (wr_hit)
  );

  assign src_eff = echo_map(src_hi);

  // Sequencer: a register write always (re)starts from byte 0, dropping
  // whatever byte was in flight.
  always_ff @(posedge clockgb) begin
    if (reset) begin
      state  <= ST_IDLE;
      index  <= 8'h00;
      data_q <= 8'h00;
    end else if (wr_hit) begin
      state <= ST_READ;
      index <= 8'h00;
    end else begin
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_READ:  state <= ST_WAIT0;
        ST_WAIT0: state <= ST_WAIT1;
        ST_WAIT1: begin
          data_q <= dma_indata;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          if (index == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            index <= index + 8'd1;
            state <= ST_READ;
          end
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Initiator bus drive. The write strobe is suppressed when a restart or
  // reset lands on the WRITE cycle so the abandoned byte never reaches OAM.
  always_comb begin
    dma_load    = 1'b0;
    dma_store   = 1'b0;
    dma_address = 16'h0000;
    dma_outdata = 8'h00;
    dma_active  = (state != ST_IDLE);
    case (state)
      ST_READ: begin
        dma_load    = 1'b1;
        dma_address = {src_eff, index};
      end
      ST_WRITE: begin
        dma_store   = !wr_hit && !reset;
        dma_address = DEST_BASE + {8'h00, index};
        dma_outdata = data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a scoreboard of expected OAM writes.
module tb_oam_dma;
  import gb_dma_pkg::*;

  localparam int          LEN  = 160;
  localparam logic [15:0] REG  = 16'hFF46;
  localparam logic [15:0] DEST = 16'hFE00;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clockgb = 1'b0;
  logic        reset, load, store;
  logic [15:0] address;
  logic [7:0]  indata, outdata;
  logic [15:0] dma_address;
  logic [7:0]  dma_outdata, dma_indata;
  logic        dma_load, dma_store, dma_active;

  always #5 clockgb = ~clockgb;

  oam_dma dut (
    .clockgb     (clockgb),
    .reset       (reset),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata),
    .load        (load),
    .store       (store),
    .dma_address (dma_address),
    .dma_outdata (dma_outdata),
    .dma_indata  (dma_indata),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .dma_active  (dma_active)
  );

  // Source memory: data = addr[7:0]^5A, valid two cycles after the strobe.
  logic [7:0] p1 = 8'hEE, p2 = 8'hEE;
  always @(posedge clockgb) begin
    p1 <= dma_load ? (dma_address[7:0] ^ 8'h5A) : 8'hEE;
    p2 <= p1;
  end
  assign dma_indata = p2;

  wr_t        sbq[$];
  int         vecs = 0, errs = 0;
  int         cyc = 0, st_cyc = 0;
  int         n_ld = 0, n_st = 0;
  int         first_ld_cyc = -1, first_st_cyc = -1, last_st_cyc = -1;
  int         exp_idx = 0;
  logic [7:0] exp_src = 8'h00;
  logic [7:0] m_src_hi = 8'h00;
  bit         busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score bus activity, advance register model.
  task automatic tick();
    wr_t w;
    @(negedge clockgb);
    chk("outdata", outdata, (load && address == REG) ? m_src_hi : 8'h00);
    chk("no_overlap", dma_load & dma_store, 0);
    if (dma_load) begin
      chk("ld_busy", busy, 1);
      chk("ld_addr", dma_address, {exp_src, 8'(exp_idx)});
      chk("ld_active", dma_active, 1);
      w.a = DEST + 16'(exp_idx);
      w.d = 8'(exp_idx) ^ 8'h5A;
      sbq.push_back(w);
      if (n_ld == 0) first_ld_cyc = cyc;
      n_ld++;
      exp_idx++;
    end
    if (dma_store) begin
      chk("st_busy", busy, 1);
      chk("st_active", dma_active, 1);
      if (sbq.size() == 0) chk("st_pending", 32'(sbq.size()), 1);
      else begin
        w = sbq.pop_front();
        chk("st_addr", dma_address, w.a);
        chk("st_data", dma_outdata, w.d);
      end
      if (n_st == 0) first_st_cyc = cyc;
      n_st++;
      if (n_st == LEN) last_st_cyc = cyc;
    end
    if (reset) m_src_hi = 8'h00;
    else if (store && address == REG) m_src_hi = indata;
    @(posedge clockgb);
    cyc++;
    #1;
  endtask

  task automatic start(input logic [7:0] val, input logic [7:0] src, input logic rd);
    address = REG; indata = val; store = 1'b1; load = rd;
    sbq.delete();
    exp_src = src; exp_idx = 0; n_ld = 0; n_st = 0;
    first_ld_cyc = -1; first_st_cyc = -1; last_st_cyc = -1;
    busy = 1'b1;
    st_cyc = cyc;
    tick();
    store = 1'b0; load = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic wait_stores(input int n, input int budget);
    int k = 0;
    while (n_st < n && k < budget) begin
      tick();
      k++;
    end
    chk("store_count", n_st, n);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"},   dma_address, 0);
    chk({tag, "_odata"},  dma_outdata, 0);
    chk({tag, "_load"},   dma_load, 0);
    chk({tag, "_store"},  dma_store, 0);
    chk({tag, "_active"}, dma_active, 0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b1; store = 1'b0; address = REG; indata = 8'h00;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_rd", outdata, 8'h00);
    reset = 1'b0; load = 1'b0; address = 16'h0000;
    tick();

    // Basic transfer from C100 with timing and readback
    start(8'hC1, 8'hC1, 1'b0);
    wait_stores(20, 200);
    load = 1'b1; address = REG;   tick();
    chk("rd_reg", outdata, 8'hC1);
    address = 16'hFF47;           tick();
    chk("rd_other", outdata, 8'h00);
    load = 1'b0; address = 16'h0000;
    wait_stores(LEN, 700);
    chk("first_ld_cyc", first_ld_cyc, st_cyc + 1);
    chk("first_st_cyc", first_st_cyc, st_cyc + 4);
    chk("last_st_cyc",  last_st_cyc,  st_cyc + 4 * LEN);
    tick();
    tick();
    chk_idle("done1");
    chk("loads1", n_ld, LEN);
    chk("sbq_empty1", 32'(sbq.size()), 0);

    // Echo RAM source maps E3 -> C3
    start(8'hE3, 8'hC3, 1'b0);
    wait_stores(LEN, 700);
    tick();
    chk_idle("done2");
    chk("loads2", n_ld, LEN);

    // Restart landing on the WRITE cycle of byte 50, with same-cycle readback
    start(8'h80, 8'h80, 1'b0);
    wait_stores(50, 300);
    tick(); tick(); tick();
    start(8'h90, 8'h90, 1'b1);
    chk("restart_st", n_st, 0);
    wait_stores(LEN, 700);
    tick();
    chk_idle("done3");
    chk("loads3", n_ld, LEN);

    // Reset during WAIT1 of byte 10
    start(8'h12, 8'h12, 1'b0);
    wait_stores(10, 100);
    tick(); tick();
    chk("pre_rst_active", dma_active, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy = 1'b0;
    sbq.delete();
    chk_idle("rst_mid");
    load = 1'b1; address = REG;
    tick();
    chk("rst_rd", outdata, 8'h00);
    load = 1'b0; address = 16'h0000;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_no_store", n_st, 10);
    chk_idle("rst_end");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
